head_table_lookup: RTL and testbench
====================================

# head_table_lookup

Hash-table front stage: accepts `ht_command_t` requests, computes the bucket index with the dummy hash, and reads the bucket's head pointer from an internal head RAM. It emits `ht_pdata_t` to the data-table stage immediately downstream. It owns the head RAM: the downstream stage updates heads through a write port, and read/write hazards are resolved here. After reset it clears the whole head RAM before accepting traffic.

## Interface

- `KEY_WIDTH`, 32, key width (matches `hash_table` package)
- `VALUE_WIDTH`, 16, value width
- `BUCKET_WIDTH`, 8, bucket index width; head RAM depth = 2^BUCKET_WIDTH
- `HEAD_PTR_WIDTH`, 10, data-table pointer width
- `clk_i`  in  1  single clock, all logic on rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `cmd_i`  in  `ht_command_t`  incoming command
- `cmd_valid_i`  in  1  command valid
- `cmd_ready_o`  out  1  command accepted when valid && ready
- `pdata_o`  out  `ht_pdata_t`  command + bucket + head_ptr + head_ptr_val
- `pdata_valid_o`  out  1  pdata valid
- `pdata_ready_i`  in  1  downstream accepts when valid && ready
- `head_wr_en_i`  in  1  head RAM write strobe from data-table stage
- `head_wr_bucket_i`  in  BUCKET_WIDTH  bucket to write
- `head_wr_data_i`  in  `head_ram_data_t`  new {ptr, ptr_val}
- `init_done_o`  out  1  head RAM clear complete

## Operation

- Hash: bucket = cmd_i.key[BUCKET_WIDTH-1:0]; pure function, no state.
- FSM states: INIT, RUN.
  - INIT is entered on reset. An init counter (BUCKET_WIDTH+1 bits) writes {ptr=0, ptr_val=0} to bucket 0, 1, …, 2^BUCKET_WIDTH-1, one bucket per cycle.
  - After the last bucket is written, the FSM moves to RUN and init_done_o goes high. It stays in RUN until the next reset.
  - In INIT, cmd_ready_o=0 and head_wr_en_i is ignored.
- Pipeline: stage A (cmd, bucket, valid, RAM read in flight) feeds the output register (pdata_o, pdata_valid_o).
  - advance = !pdata_valid_o || pdata_ready_i.
  - cmd_ready_o = init_done && (!stageA_valid || advance).
- RAM read address:
  - The incoming bucket on accept.
  - Otherwise the stage-A bucket, so a stalled read is refreshed every cycle.
- On advance, stage A transfers to the output register and stage A valid drops unless a new command is accepted in the same cycle.
- Head coherence invariant: in every cycle with pdata_valid_o=1, pdata_o.head_ptr/head_ptr_val equal the head RAM contents of pdata_o.bucket including all writes from every earlier cycle. This requires:
  - Forwarding a same-cycle write that hits a bucket being read by stage A.
  - Forwarding a write that hits stage A's bucket in the transfer cycle.
  - Updating the held output register when a write hits pdata_o.bucket while stalled.
- A write and a read to the same bucket in the same cycle never return stale data.
- All opcodes (SEARCH/INSERT/DELETE) are treated identically. The cmd field passes through unmodified.
- Order is preserved; no command is dropped or duplicated.

## Timing

- Reset values:
  - cmd_ready_o=0, pdata_valid_o=0, pdata_o=0, init_done_o=0.
  - Stage A valid=0, FSM=INIT, init counter=0.
- Init duration: init_done_o rises exactly 2^BUCKET_WIDTH cycles after rst_i deasserts (256 at default). cmd_ready_o may rise in the same cycle.
- Latency: a command accepted in cycle t appears on pdata_valid_o in cycle t+2 when there is no backpressure.
- Throughput: one command per cycle sustained.
- Backpressure:
  - pdata_o is held stable while valid && !ready, except for head fields updated by a hitting write.
  - Stage A holds. cmd_ready_o drops only once stage A and the output register are both full.
- Head write: takes effect in the RAM at the next edge and is visible to any lookup whose read occurs in that cycle or later.
- Reset mid-operation:
  - In-flight commands are discarded immediately (async).
  - The FSM restarts INIT from bucket 0.
  - Outputs return to their reset values.

## Test plan

- Reset release, idle -> init_done_o and cmd_ready_o rise after exactly 256 cycles. A read-back lookup of every bucket 0x00–0xFF returns head_ptr_val=0.
- After init, SEARCH key=0x0000_1234 accepted in cycle t -> pdata_valid_o in t+2 with bucket=0x34, head_ptr_val=0, cmd unchanged.
- head write bucket=0x34 {ptr=5, val=1}, then SEARCH key=0xABCD_0034 next cycle -> head_ptr=5, head_ptr_val=1. Repeat with the write in the same cycle as the command accept, and again in the transfer cycle -> same result.
- Stream of 8 commands with pdata_ready_i=0 for 10 cycles:
  - cmd_ready_o drops after 2 accepts and pdata_o stays stable.
  - A write bucket=pdata_o.bucket {ptr=0x3FF, val=1} during the stall updates the held head fields next cycle.
  - Releasing ready delivers all 8 commands in order, back-to-back.
- Assert rst_i with 2 commands in flight and a pending write -> pdata_valid_o=0 immediately. The full 256-cycle INIT reruns and the previously written bucket reads ptr_val=0.
- Random mix of commands and writes over 10k cycles against a reference head-array model -> every pdata matches the model, with order preserved.

Source files
------------

// File: rtl/head_table_lookup.sv
// Hash-table front stage: hashes the key to a bucket and reads that bucket's head pointer from the head RAM.
// Latency: 2 cycles from command accept to pdata valid; sustains one command per cycle.
// Backpressure: valid/ready; stage A and the output register each hold one entry, so cmd_ready_o drops only when both are full.

package hash_table;
    localparam int KEY_WIDTH      = 32;
    localparam int VALUE_WIDTH    = 16;
    localparam int BUCKET_WIDTH   = 8;
    localparam int HEAD_PTR_WIDTH = 10;

    typedef enum logic [1:0] {
        HT_SEARCH = 2'd0,
        HT_INSERT = 2'd1,
        HT_DELETE = 2'd2
    } ht_opcode_t;

    typedef struct packed {
        ht_opcode_t             opcode;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } ht_command_t;

    typedef struct packed {
        logic [HEAD_PTR_WIDTH-1:0] ptr;
        logic                      ptr_val;
    } head_ram_data_t;

    typedef struct packed {
        ht_command_t               cmd;
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic [HEAD_PTR_WIDTH-1:0] head_ptr;
        logic                      head_ptr_val;
    } ht_pdata_t;
endpackage

module head_table_lookup #(
    parameter int KEY_WIDTH      = hash_table::KEY_WIDTH,
    parameter int VALUE_WIDTH    = hash_table::VALUE_WIDTH,
    parameter int BUCKET_WIDTH   = hash_table::BUCKET_WIDTH,
    parameter int HEAD_PTR_WIDTH = hash_table::HEAD_PTR_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  hash_table::ht_command_t    cmd_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    output hash_table::ht_pdata_t      pdata_o,
    output logic                       pdata_valid_o,
    input  logic                       pdata_ready_i,
    input  logic                       head_wr_en_i,
    input  logic [BUCKET_WIDTH-1:0]    head_wr_bucket_i,
    input  hash_table::head_ram_data_t head_wr_data_i,
    output logic                       init_done_o
);
    localparam int DEPTH = 1 << BUCKET_WIDTH;
    // The stage-A command is carried as a flat vector sized from the module parameters;
    // these must agree with the hash_table package widths.
    localparam int CMD_W = $bits(hash_table::ht_opcode_t) + KEY_WIDTH + VALUE_WIDTH;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [BUCKET_WIDTH:0] LAST_BUCKET = {1'b0, {BUCKET_WIDTH{1'b1}}};
    localparam logic [BUCKET_WIDTH:0] CNT_ONE     = {{BUCKET_WIDTH{1'b0}}, 1'b1};

    logic [0:0]                r_state;
    logic [BUCKET_WIDTH:0]     r_init_cnt;
    logic [HEAD_PTR_WIDTH:0]   r_mem [DEPTH];
    logic [HEAD_PTR_WIDTH:0]   r_rd_data;
    logic                      r_a_vld;
    logic [CMD_W-1:0]          r_a_cmd;
    logic [BUCKET_WIDTH-1:0]   r_a_bucket;
    hash_table::ht_pdata_t     r_out;
    logic                      r_out_vld;

    logic                      w_init_done;
    logic                      w_advance;
    logic                      w_accept;
    logic [BUCKET_WIDTH-1:0]   w_cmd_bucket;
    logic [BUCKET_WIDTH-1:0]   w_rd_addr;
    logic                      w_wr_en;
    logic [BUCKET_WIDTH-1:0]   w_wr_addr;
    logic [HEAD_PTR_WIDTH:0]   w_wr_data;
    logic [HEAD_PTR_WIDTH:0]   w_rd_next;
    logic [HEAD_PTR_WIDTH:0]   w_a_head;
    logic                      w_out_hit;

    assign w_init_done  = (r_state == ST_RUN);
    assign w_advance    = !r_out_vld || pdata_ready_i;
    assign cmd_ready_o  = w_init_done && (!r_a_vld || w_advance);
    assign w_accept     = cmd_valid_i && cmd_ready_o;
    assign w_cmd_bucket = cmd_i.key[BUCKET_WIDTH-1:0];

    // A new command reads its own bucket; otherwise stage A re-reads so a stalled entry never goes stale.
    assign w_rd_addr = w_accept ? w_cmd_bucket : r_a_bucket;

    // During INIT the clear sequence owns the write port and external writes are dropped.
    assign w_wr_en   = w_init_done ? head_wr_en_i     : 1'b1;
    assign w_wr_addr = w_init_done ? head_wr_bucket_i : r_init_cnt[BUCKET_WIDTH-1:0];
    assign w_wr_data = w_init_done ? head_wr_data_i   : '0;

    // Same-cycle write to the bucket being read wins over the old RAM contents.
    assign w_rd_next = (w_wr_en && (w_wr_addr == w_rd_addr)) ? w_wr_data : r_mem[w_rd_addr];
    // A write landing on stage A's bucket in the transfer cycle is forwarded into the output register.
    assign w_a_head  = (w_wr_en && (w_wr_addr == r_a_bucket)) ? w_wr_data : r_rd_data;
    // A write landing on the held output bucket while stalled patches the head fields in place.
    assign w_out_hit = r_out_vld && w_wr_en && (w_wr_addr == r_out.bucket);

    assign pdata_o       = r_out;
    assign pdata_valid_o = r_out_vld;
    assign init_done_o   = w_init_done;

    // Clear sequence: one bucket per cycle, then RUN until the next reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + CNT_ONE;
            if (r_init_cnt == LAST_BUCKET) begin
                r_state <= ST_RUN;
            end
        end
    end

    // Head RAM storage; contents are rebuilt by the clear sequence after every reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Registered head read, refreshed every cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_next;
        end
    end

    // Stage A: holds the accepted command while its head read is in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_a_vld    <= 1'b0;
            r_a_cmd    <= '0;
            r_a_bucket <= '0;
        end else if (w_accept) begin
            r_a_vld    <= 1'b1;
            r_a_cmd    <= cmd_i;
            r_a_bucket <= w_cmd_bucket;
        end else if (w_advance) begin
            r_a_vld    <= 1'b0;
        end
    end

    // Output register: loads from stage A on advance, otherwise holds with head-field patching.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else if (w_advance) begin
            r_out_vld <= r_a_vld;
            if (r_a_vld) begin
                r_out.cmd                          <= hash_table::ht_command_t'(r_a_cmd);
                r_out.bucket                       <= r_a_bucket;
                {r_out.head_ptr, r_out.head_ptr_val} <= w_a_head;
            end
        end else if (w_out_hit) begin
            {r_out.head_ptr, r_out.head_ptr_val} <= w_wr_data;
        end
    end
endmodule

// File: tb/tb_head_table_lookup.sv
// Self-checking bench for head_table_lookup: directed steps followed by a random command/write mix.
// The reference keeps a plain array of bucket heads plus a queue of accepted commands in order.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.

module tb_head_table_lookup;
    import hash_table::*;

    logic           clk_i = 1'b0;
    logic           rst_i;
    ht_command_t    cmd_i;
    logic           cmd_valid_i;
    logic           cmd_ready_o;
    ht_pdata_t      pdata_o;
    logic           pdata_valid_o;
    logic           pdata_ready_i;
    logic           head_wr_en_i;
    logic [7:0]     head_wr_bucket_i;
    head_ram_data_t head_wr_data_i;
    logic           init_done_o;

    head_table_lookup dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .cmd_i            (cmd_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .pdata_o          (pdata_o),
        .pdata_valid_o    (pdata_valid_o),
        .pdata_ready_i    (pdata_ready_i),
        .head_wr_en_i     (head_wr_en_i),
        .head_wr_bucket_i (head_wr_bucket_i),
        .head_wr_data_i   (head_wr_data_i),
        .init_done_o      (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    int             checks = 0;
    int             errors = 0;
    head_ram_data_t ref_head [256];
    ht_command_t    exp_q [$];
    logic           last_acc = 1'b0;
    int             n_xfer = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    function automatic ht_command_t mk(input ht_opcode_t op, input logic [31:0] key, input logic [15:0] val);
        ht_command_t c;
        c.opcode = op;
        c.key    = key;
        c.value  = val;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_head[i] = '0;
        exp_q.delete();
    endtask

    // One clock cycle: check outputs against the reference, update it, advance to the next falling edge.
    task automatic step();
        ht_command_t e_cmd;
        #1;
        last_acc = cmd_valid_i && cmd_ready_o;
        if (pdata_valid_o) begin
            chk("coherence", 128'({pdata_o.head_ptr, pdata_o.head_ptr_val}), 128'(ref_head[pdata_o.bucket]));
            if (pdata_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 128'(pdata_valid_o), 128'(0));
                end else begin
                    e_cmd = exp_q.pop_front();
                    chk("order_cmd", 128'(pdata_o.cmd), 128'(e_cmd));
                    chk("order_bucket", 128'(pdata_o.bucket), 128'(e_cmd.key[7:0]));
                    n_xfer++;
                end
            end
        end
        if (last_acc) exp_q.push_back(cmd_i);
        if (head_wr_en_i && init_done_o) ref_head[head_wr_bucket_i] = head_wr_data_i;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic send(input ht_command_t c);
        int tries = 0;
        cmd_i       = c;
        cmd_valid_i = 1'b1;
        do begin
            step();
            tries++;
        end while (!last_acc && tries < 50);
        if (!last_acc) chk("send_timeout", 128'(cmd_ready_o), 128'(1));
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        cmd_valid_i   = 1'b0;
        head_wr_en_i  = 1'b0;
        pdata_ready_i = 1'b1;
        while ((exp_q.size() != 0 || pdata_valid_o) && t < 100) begin
            step();
            t++;
        end
        chk("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done_o && n < 1000) begin
            @(posedge clk_i);
            n++;
            #1;
        end
        @(negedge clk_i);
    endtask

    task automatic do_write(input logic [7:0] b, input logic [9:0] p, input logic v);
        head_wr_en_i        = 1'b1;
        head_wr_bucket_i    = b;
        head_wr_data_i.ptr     = p;
        head_wr_data_i.ptr_val = v;
    endtask

    initial begin
        int          n;
        int          k;
        ht_command_t c0;
        ht_command_t list [8];
        ht_pdata_t   snap;
        logic [31:0] rk;

        rst_i            = 1'b0;
        cmd_i            = '0;
        cmd_valid_i      = 1'b0;
        pdata_ready_i    = 1'b0;
        head_wr_en_i     = 1'b0;
        head_wr_bucket_i = '0;
        head_wr_data_i   = '0;
        snap             = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_cmd_ready", 128'(cmd_ready_o), 128'(0));
        chk("rst_pdata_valid", 128'(pdata_valid_o), 128'(0));
        chk("rst_pdata", 128'(pdata_o), 128'(0));
        chk("rst_init_done", 128'(init_done_o), 128'(0));

        // Init duration
        rst_i = 1'b1;
        wait_init(n);
        chk("init_cycles", 128'(n), 128'(256));
        chk("init_cmd_ready", 128'(cmd_ready_o), 128'(1));

        // Read back every bucket: all heads must be clear
        pdata_ready_i = 1'b1;
        for (int i = 0; i < 256; i++) send(mk(HT_SEARCH, {16'hC0DE, 8'h00, 8'(i)}, 16'(i)));
        drain();

        // Latency and pass-through
        c0 = mk(HT_SEARCH, 32'h0000_1234, 16'hBEEF);
        send(c0);
        chk("lat_t1_valid", 128'(pdata_valid_o), 128'(0));
        step();
        chk("lat_t2_valid", 128'(pdata_valid_o), 128'(1));
        chk("lat_bucket", 128'(pdata_o.bucket), 128'(8'h34));
        chk("lat_ptr_val", 128'(pdata_o.head_ptr_val), 128'(0));
        chk("lat_cmd", 128'(pdata_o.cmd), 128'(c0));

        // Write in an earlier cycle
        do_write(8'h34, 10'd5, 1'b1);
        step();
        head_wr_en_i = 1'b0;
        send(mk(HT_SEARCH, 32'hABCD_0034, 16'h0001));
        step();
        chk("wr_before_ptr", 128'(pdata_o.head_ptr), 128'(5));
        chk("wr_before_val", 128'(pdata_o.head_ptr_val), 128'(1));

        // Write in the accept cycle
        do_write(8'h34, 10'd7, 1'b1);
        send(mk(HT_INSERT, 32'hABCD_0034, 16'h0002));
        head_wr_en_i = 1'b0;
        step();
        chk("wr_accept_ptr", 128'(pdata_o.head_ptr), 128'(7));
        chk("wr_accept_val", 128'(pdata_o.head_ptr_val), 128'(1));

        // Write in the transfer cycle
        send(mk(HT_DELETE, 32'hABCD_0034, 16'h0003));
        do_write(8'h34, 10'd9, 1'b1);
        step();
        head_wr_en_i = 1'b0;
        chk("wr_xfer_ptr", 128'(pdata_o.head_ptr), 128'(9));
        chk("wr_xfer_val", 128'(pdata_o.head_ptr_val), 128'(1));
        drain();

        // Stall with 8 commands offered
        for (int i = 0; i < 8; i++) list[i] = mk(ht_opcode_t'(i % 3), {16'h5A00, 8'h00, 8'(8'h40 + i)}, 16'(i));
        pdata_ready_i = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            cmd_valid_i = (k < 8);
            if (k < 8) cmd_i = list[k];
            if (cyc == 6) do_write(8'h40, 10'h3FF, 1'b1);
            step();
            head_wr_en_i = 1'b0;
            if (last_acc) k++;
            if (cyc == 3) begin
                snap = pdata_o;
                chk("stall_accepts", 128'(k), 128'(2));
                chk("stall_ready", 128'(cmd_ready_o), 128'(0));
                chk("stall_cmd", 128'(pdata_o.cmd), 128'(list[0]));
            end
            if (cyc == 5) chk("stall_stable", 128'(pdata_o), 128'(snap));
            if (cyc == 6) begin
                chk("stall_wr_ptr", 128'(pdata_o.head_ptr), 128'(10'h3FF));
                chk("stall_wr_val", 128'(pdata_o.head_ptr_val), 128'(1));
                chk("stall_wr_cmd", 128'(pdata_o.cmd), 128'(snap.cmd));
            end
        end
        chk("stall_accepts_end", 128'(k), 128'(2));
        pdata_ready_i = 1'b1;
        n_xfer = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            cmd_valid_i = (k < 8);
            if (k < 8) cmd_i = list[k];
            step();
            if (last_acc) k++;
        end
        cmd_valid_i = 1'b0;
        chk("b2b_xfers", 128'(n_xfer), 128'(8));
        drain();

        // Reset mid-operation
        do_write(8'h77, 10'h055, 1'b1);
        step();
        head_wr_en_i  = 1'b0;
        pdata_ready_i = 1'b0;
        send(mk(HT_SEARCH, 32'h0000_0077, 16'h00AA));
        send(mk(HT_SEARCH, 32'h0000_0078, 16'h00BB));
        do_write(8'h78, 10'h066, 1'b1);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(pdata_valid_o), 128'(0));
        chk("mid_rst_pdata", 128'(pdata_o), 128'(0));
        chk("mid_rst_ready", 128'(cmd_ready_o), 128'(0));
        chk("mid_rst_init", 128'(init_done_o), 128'(0));
        head_wr_en_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        wait_init(n);
        chk("reinit_cycles", 128'(n), 128'(256));
        pdata_ready_i = 1'b1;
        send(mk(HT_SEARCH, 32'h1111_1177, 16'h00CC));
        step();
        chk("reinit_bucket", 128'(pdata_o.bucket), 128'(8'h77));
        chk("reinit_ptr_val", 128'(pdata_o.head_ptr_val), 128'(0));
        drain();

        // Random mix over a narrow bucket range so writes often hit in-flight lookups
        for (int cyc = 0; cyc < 10000; cyc++) begin
            pdata_ready_i = ($urandom_range(0, 9) < 7);
            cmd_valid_i   = ($urandom_range(0, 9) < 6);
            rk            = $urandom();
            rk[7:0]       = 8'($urandom_range(0, 15));
            cmd_i         = mk(ht_opcode_t'($urandom_range(0, 2)), rk, 16'($urandom()));
            head_wr_en_i  = ($urandom_range(0, 9) < 3);
            head_wr_bucket_i       = 8'($urandom_range(0, 15));
            head_wr_data_i.ptr     = 10'($urandom());
            head_wr_data_i.ptr_val = 1'($urandom());
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
